// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multicycle RISC-V control unit: FSM states, opcodes,
// datapath mux encodings and the packed control word produced per state.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_ALU    = 2'b10
  } res_src_e;

  typedef struct packed {
    logic     mem_req;
    logic     mem_we;
    logic     adr_src;
    logic     ir_write;
    logic     pc_write;
    logic     reg_write;
    logic     is_jalr;
    logic     trap;
    srca_e    alu_src_a;
    srcb_e    alu_src_b;
    alu_op_e  alu_op;
    res_src_e result_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mc_out_decode.sv
// State-to-control-word lookup. Purely combinational; the only non-state
// inputs that matter are mem_ready (FETCH), br_taken (BRANCH) and op (UPPER).
module mc_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  input  logic       br_taken_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave a
    // signal unassigned, which would otherwise infer a latch.
    ctrl_o = CTRL_NONE;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.ir_write   = 1'b1;
          ctrl_o.pc_write   = 1'b1;
          ctrl_o.alu_src_a  = SRCA_PC;
          ctrl_o.alu_src_b  = SRCB_FOUR;
          ctrl_o.alu_op     = ALUOP_ADD;
          ctrl_o.result_src = RES_ALU;
        end
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_MEM;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.adr_src = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_RS2;
        ctrl_o.alu_op     = ALUOP_BRANCH;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_write   = br_taken_i;
      end
      S_JAL: begin
        // ALUOut already holds PC+imm from DECODE.
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_write   = 1'b1;
      end
      S_JALR: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.is_jalr    = 1'b1;
        ctrl_o.pc_write   = 1'b1;
      end
      S_LINK: begin
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.reg_write  = 1'b1;
      end
      S_UPPER: begin
        if (op_i == OP_LUI) ctrl_o.alu_src_a = SRCA_ZERO;
        else                ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_TRAP: begin
        ctrl_o.trap = 1'b1;
      end
      default: ctrl_o = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: state register and next-state logic; the
// per-state control word comes from mc_out_decode and is forced to 0 in reset.
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       is_jalr,
  output logic       trap,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] branch_type,
  output logic [2:0] load_type,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_g;

  // NOTE: reset is sampled on the clock edge only (synchronous), and state
  // uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL,
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_FETCH;
      S_UPPER:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      // The one unused encoding is treated as a fault and parks in TRAP.
      default:    state_d = S_TRAP;
    endcase
  end

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
    .br_taken_i  (br_taken),
    .ctrl_o      (ctrl)
  );

  // Gating by rst_n drops an in-flight memory request in the reset cycle itself.
  assign ctrl_g = rst_n ? ctrl : CTRL_NONE;

  assign mem_req     = ctrl_g.mem_req;
  assign mem_we      = ctrl_g.mem_we;
  assign adr_src     = ctrl_g.adr_src;
  assign ir_write    = ctrl_g.ir_write;
  assign pc_write    = ctrl_g.pc_write;
  assign reg_write   = ctrl_g.reg_write;
  assign is_jalr     = ctrl_g.is_jalr;
  assign trap        = ctrl_g.trap;
  assign alu_src_a   = ctrl_g.alu_src_a;
  assign alu_src_b   = ctrl_g.alu_src_b;
  assign alu_op      = ctrl_g.alu_op;
  assign result_src  = ctrl_g.result_src;
  assign branch_type = funct3;
  assign load_type   = funct3;
  assign state       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: latency/count table, directed corner
// sequences and randomized instruction streams against an instruction-level model.
module tb_multicycle_controller;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;
  localparam logic [6:0] T_ITYPE  = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, is_jalr, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] branch_type, load_type;
  logic [3:0] state;

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .is_jalr     (is_jalr),
    .trap        (trap),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .result_src  (result_src),
    .branch_type (branch_type),
    .load_type   (load_type),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Expected control word, field order matches the output list.
  typedef struct packed {
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, is_jalr, trap;
    logic [1:0] a, b, aop, rsrc;
  } exp_t;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR, P_EXECI,
    P_ALUWB, P_BRANCH, P_JAL, P_JALR, P_LINK, P_UPPER, P_TRAP
  } phase_e;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       bt;
    int         lat;
    int         regw;
    int         pcw;
    int         mreq;
    int         mwe;
  } vec_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  phase_e plan[$];
  vec_t   vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t act_word();
    return {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, is_jalr, trap,
            alu_src_a, alu_src_b, alu_op, result_src};
  endfunction

  // Control word each phase should present, straight from the output table.
  function automatic exp_t expect_of(phase_e p, logic rdy, logic bt, logic [6:0] o);
    exp_t e = '0;
    case (p)
      P_FETCH: begin
        e.mem_req = 1'b1;
        if (rdy) begin
          e.ir_write = 1'b1; e.pc_write = 1'b1; e.b = 2'b10; e.rsrc = 2'b10;
        end
      end
      P_DECODE:   begin e.a = 2'b01; e.b = 2'b01; end
      P_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
      P_MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
      P_MEMWB:    begin e.rsrc = 2'b01; e.reg_write = 1'b1; end
      P_MEMWRITE: begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; end
      P_EXECR:    begin e.a = 2'b10; e.b = 2'b00; e.aop = 2'b10; end
      P_EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
      P_ALUWB:    begin e.reg_write = 1'b1; end
      P_BRANCH:   begin e.a = 2'b10; e.aop = 2'b01; e.pc_write = bt; end
      P_JAL:      begin e.pc_write = 1'b1; end
      P_JALR: begin
        e.a = 2'b10; e.b = 2'b01; e.rsrc = 2'b10; e.is_jalr = 1'b1; e.pc_write = 1'b1;
      end
      P_LINK:     begin e.a = 2'b01; e.b = 2'b10; e.rsrc = 2'b10; e.reg_write = 1'b1; end
      P_UPPER:    begin e.a = (o == T_LUI) ? 2'b11 : 2'b01; e.b = 2'b01; end
      P_TRAP:     begin e.trap = 1'b1; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  // Phase sequence an instruction walks through, by opcode class.
  task automatic build_plan(input logic [6:0] o);
    plan = {};
    plan.push_back(P_FETCH);
    plan.push_back(P_DECODE);
    case (o)
      T_LOAD:          begin plan.push_back(P_MEMADR); plan.push_back(P_MEMREAD); plan.push_back(P_MEMWB); end
      T_STORE:         begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWRITE); end
      T_RTYPE:         begin plan.push_back(P_EXECR); plan.push_back(P_ALUWB); end
      T_ITYPE:         begin plan.push_back(P_EXECI); plan.push_back(P_ALUWB); end
      T_BRANCH:        plan.push_back(P_BRANCH);
      T_JAL:           begin plan.push_back(P_JAL); plan.push_back(P_LINK); end
      T_JALR:          begin plan.push_back(P_JALR); plan.push_back(P_LINK); end
      T_LUI, T_AUIPC:  begin plan.push_back(P_UPPER); plan.push_back(P_ALUWB); end
      default:         plan.push_back(P_TRAP);
    endcase
  endtask

  // One clock: drive, compare away from the edge, advance to the next low phase.
  task automatic step(input phase_e p, input logic rdy, input logic bt);
    mem_ready = rdy;
    br_taken  = bt;
    #1;
    check($sformatf("%s ctrl op=%0h", p.name(), op), act_word(), expect_of(p, rdy, bt, op));
    check($sformatf("%s funct3 passthrough", p.name()), {branch_type, load_type}, {funct3, funct3});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    br_taken  = 1'b1;
    #1;
    check("reset ctrl", act_word(), 32'd0);
    check("reset state", state, 32'd0);
    check("reset funct3 passthrough", {branch_type, load_type}, {funct3, funct3});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // btm: 0/1 fixed branch outcome, 2 random.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input int fw,
                           input int mw, input int btm);
    op     = o;
    funct3 = f3;
    build_plan(o);
    foreach (plan[i]) begin
      case (plan[i])
        P_FETCH:
          for (int w = 0; w <= fw; w++) step(P_FETCH, w == fw, 1'($urandom));
        P_MEMREAD, P_MEMWRITE:
          for (int w = 0; w <= mw; w++) step(plan[i], w == mw, 1'($urandom));
        P_BRANCH:
          step(P_BRANCH, 1'($urandom), (btm == 2) ? 1'($urandom) : (btm == 1));
        P_TRAP:
          for (int w = 0; w < 3; w++) step(P_TRAP, 1'($urandom), 1'($urandom));
        default:
          step(plan[i], 1'($urandom), 1'($urandom));
      endcase
    end
  endtask

  // Zero-wait run from FETCH back to FETCH, counting cycles and strobes.
  task automatic run_vec(input vec_t v);
    int cyc = 0, regw = 0, pcw = 0, mreq = 0, mwe = 0;
    logic [3:0] s0 = '0;
    op        = v.op;
    funct3    = v.f3;
    br_taken  = v.bt;
    mem_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c == 0) s0 = state;
      else if (state == s0) break;
      cyc++;
      regw += int'(reg_write);
      pcw  += int'(pc_write);
      mreq += int'(mem_req);
      mwe  += int'(mem_we);
      @(posedge clk);
      @(negedge clk);
    end
    check({v.name, " latency"}, cyc, v.lat);
    check({v.name, " reg_write cycles"}, regw, v.regw);
    check({v.name, " pc_write cycles"}, pcw, v.pcw);
    check({v.name, " mem_req cycles"}, mreq, v.mreq);
    check({v.name, " mem_we cycles"}, mwe, v.mwe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal[10];
    logic [6:0] bad[3];

    vecs[0] = '{"add",    T_RTYPE,  3'd0, 1'b0, 4, 1, 1, 1, 0};
    vecs[1] = '{"addi",   T_ITYPE,  3'd1, 1'b0, 4, 1, 1, 1, 0};
    vecs[2] = '{"lw",     T_LOAD,   3'd2, 1'b0, 5, 1, 1, 2, 0};
    vecs[3] = '{"sw",     T_STORE,  3'd2, 1'b0, 4, 0, 1, 2, 1};
    vecs[4] = '{"beq_nt", T_BRANCH, 3'd0, 1'b0, 3, 0, 1, 1, 0};
    vecs[5] = '{"beq_t",  T_BRANCH, 3'd0, 1'b1, 3, 0, 2, 1, 0};
    vecs[6] = '{"jal",    T_JAL,    3'd0, 1'b0, 4, 1, 2, 1, 0};
    vecs[7] = '{"jalr",   T_JALR,   3'd0, 1'b0, 4, 1, 2, 1, 0};
    vecs[8] = '{"lui",    T_LUI,    3'd5, 1'b0, 4, 1, 1, 1, 0};
    vecs[9] = '{"auipc",  T_AUIPC,  3'd7, 1'b1, 4, 1, 1, 1, 0};

    legal = '{T_LOAD, T_STORE, T_RTYPE, T_ITYPE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC, T_RTYPE};
    bad   = '{7'b1111111, 7'b0001111, 7'b1110011};

    op = T_RTYPE; funct3 = 3'd0; mem_ready = 1'b0; br_taken = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    // add x3,x1,x2; lw with three wait states; beq not-taken then taken; jalr
    run_instr(T_RTYPE, 3'd0, 0, 0, 0);
    run_instr(T_LOAD, 3'b010, 0, 3, 0);
    run_instr(T_BRANCH, 3'b000, 0, 0, 0);
    run_instr(T_BRANCH, 3'b000, 0, 0, 1);
    run_instr(T_JALR, 3'b000, 2, 0, 0);

    // Illegal opcode traps and holds until reset.
    op = 7'b1111111; funct3 = 3'd3;
    step(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(P_TRAP, 1'($urandom), 1'($urandom));
    do_reset();
    step(P_FETCH, 1'b0, 1'b0);
    run_instr(T_ITYPE, 3'd4, 1, 0, 0);

    // Reset while a store is waiting on memory abandons the access.
    op = T_STORE; funct3 = 3'd1;
    step(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, 1'b0, 1'b0);
    step(P_MEMADR, 1'b0, 1'b0);
    step(P_MEMWRITE, 1'b0, 1'b0);
    step(P_MEMWRITE, 1'b0, 1'b0);
    do_reset();
    run_instr(T_STORE, 3'd1, 0, 1, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        run_instr(bad[$urandom_range(0, 2)], 3'($urandom), $urandom_range(0, 3), 0, 2);
        do_reset();
      end else begin
        run_instr(legal[$urandom_range(0, 9)], 3'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
